// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU execution-rate controller.
//   STEP_COUNT_W : width of the issued-pulse counter
//   ST_*         : 2-bit controller state encodings (kept as plain constants
//                  so legacy code comparing against raw values still works)
package clk_ctrl_pkg;

  localparam int STEP_COUNT_W = 16;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_STEP    = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw board push-button.
//   CLK        : system clock
//   RESET      : asynchronous, active-high reset
//   btn_raw    : raw, bouncing, active-high button input (asynchronous)
//   btn_stable : accepted button level after debouncing
//   btn_rise   : one-cycle pulse in the cycle after btn_stable goes 0->1
// A level change is accepted once the synchronized input has disagreed with
// the accepted level for 2^DEBOUNCE_BITS consecutive cycles.
module button_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_raw,
  output logic btn_stable,
  output logic btn_rise
);

  logic                     sync1;
  logic                     sync2;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     disagree;
  logic                     expire;

  always_comb begin
    disagree = (sync2 != btn_stable);
    // cnt counts prior disagreeing cycles, so all-ones marks the last one
    expire   = disagree && (cnt == '1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      btn_stable <= 1'b0;
      btn_rise   <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_rise <= expire && !btn_stable;
      if (expire) begin
        btn_stable <= ~btn_stable;
        cnt        <= '0;
      end else if (disagree) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// CPU execution-rate controller: turns RUN / STEP_BTN / HALT into
// single-cycle clock enables for the core.
//   CLK        : system clock, sole domain
//   RESET      : asynchronous, active-high reset
//   RUN        : board switch (asynchronous level), 1 = free-run
//   STEP_BTN   : raw step push-button (asynchronous, bouncing)
//   HALT       : synchronous halt request from the core (level)
//   clk_en     : one-cycle enable to the core
//   running    : high while free-running
//   step_count : number of clk_en pulses issued, wraps
// Free-run issues one enable every 2^SLOW cycles; each debounced button
// press issues exactly one enable while stopped.
module step_clock_gen
  import clk_ctrl_pkg::*;
#(
  parameter int SLOW          = 20,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RUN,
  input  logic                    STEP_BTN,
  input  logic                    HALT,
  output logic                    clk_en,
  output logic                    running,
  output logic [STEP_COUNT_W-1:0] step_count
);

  logic       run_s1;
  logic       run_s;
  logic       step_req;
  logic       unused_btn_stable;
  logic [1:0] state;
  logic [1:0] state_next;
  logic       tick;

  button_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_step_btn (
    .CLK       (CLK),
    .RESET     (RESET),
    .btn_raw   (STEP_BTN),
    .btn_stable(unused_btn_stable),
    .btn_rise  (step_req)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_s1 <= RUN;
      run_s  <= run_s1;
    end
  end

  // step_req outside STOPPED is simply dropped, never queued
  always_comb begin
    state_next = state;
    case (state)
      ST_STOPPED: begin
        if (run_s)         state_next = ST_RUNNING;
        else if (step_req) state_next = ST_STEP;
      end
      ST_RUNNING: begin
        if (HALT)        state_next = ST_HALTED;
        else if (!run_s) state_next = ST_STOPPED;
      end
      ST_STEP:     state_next = HALT ? ST_HALTED : ST_STOPPED;
      ST_HALTED: begin
        if (!run_s) state_next = ST_STOPPED;
      end
      default:     state_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_STOPPED;
    else       state <= state_next;
  end

  // Divider only advances while staying in RUNNING, so every entry starts at 0
  if (SLOW == 0) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    logic [SLOW-1:0] div;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        div <= '0;
      end else if (state == ST_RUNNING && state_next == ST_RUNNING) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
      end
    end

    assign tick = (div == '1);
  end

  always_comb begin
    running = (state == ST_RUNNING);
    clk_en  = (state == ST_STEP) || ((state == ST_RUNNING) && tick);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       step_count <= '0;
    else if (clk_en) step_count <= step_count + 1'b1;
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen: two instances (SLOW=2 and SLOW=0,
// both DEBOUNCE_BITS=3) compared every cycle against a behavioural model,
// plus hand-computed expectations for the key timing points.
module tb_step_clock_gen;

  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  typedef struct {
    bit run_h1;       // RUN sampled at the latest edge
    bit run_h2;       // RUN sampled one edge earlier (the synchronized view)
    bit btn_h1;
    bit btn_h2;
    bit btn_level;    // accepted (debounced) button level
    int disagree_run; // consecutive cycles the synced button differed
    bit press;        // accepted 0->1 at the previous edge
    int mode;
    int run_cycles;   // RUNNING cycles already completed in this visit
    int pulses;
  } model_t;

  logic clk;
  logic rst_a, run_a, btn_a, halt_a, clk_en_a, running_a;
  logic rst_b, run_b, btn_b, halt_b, clk_en_b, running_b;
  logic [15:0] step_count_a, step_count_b;
  model_t ma, mb;
  int checks = 0;
  int failures = 0;

  step_clock_gen #(.SLOW(2), .DEBOUNCE_BITS(3)) dut_a (
    .CLK(clk), .RESET(rst_a), .RUN(run_a), .STEP_BTN(btn_a), .HALT(halt_a),
    .clk_en(clk_en_a), .running(running_a), .step_count(step_count_a)
  );

  step_clock_gen #(.SLOW(0), .DEBOUNCE_BITS(3)) dut_b (
    .CLK(clk), .RESET(rst_b), .RUN(run_b), .STEP_BTN(btn_b), .HALT(halt_b),
    .clk_en(clk_en_b), .running(running_b), .step_count(step_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic model_t model_reset();
    model_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Enable is due in STEP, or on every 2^slow-th cycle of a RUNNING visit
  function automatic bit model_en(model_t m, int slow);
    return (m.mode == M_STEP) ||
           ((m.mode == M_RUN) && (((m.run_cycles + 1) % (1 << slow)) == 0));
  endfunction

  function automatic model_t model_step(model_t m, bit run, bit btn, bit halt,
                                        int slow, int dbits);
    model_t n;
    bit run_s;
    bit btn_s;
    n = m;
    run_s = m.run_h2;
    btn_s = m.btn_h2;
    if (model_en(m, slow)) n.pulses = m.pulses + 1;
    n.run_h2 = m.run_h1;
    n.run_h1 = run;
    n.btn_h2 = m.btn_h1;
    n.btn_h1 = btn;
    n.press = 1'b0;
    if (btn_s != m.btn_level) begin
      n.disagree_run = m.disagree_run + 1;
      if (n.disagree_run == (1 << dbits)) begin
        n.btn_level    = btn_s;
        n.disagree_run = 0;
        n.press        = btn_s;
      end
    end else begin
      n.disagree_run = 0;
    end
    case (m.mode)
      M_STOP: begin
        if (run_s) begin
          n.mode = M_RUN;
          n.run_cycles = 0;
        end else if (m.press) begin
          n.mode = M_STEP;
        end
      end
      M_RUN: begin
        if (halt)        n.mode = M_HALT;
        else if (!run_s) n.mode = M_STOP;
        else             n.run_cycles = m.run_cycles + 1;
      end
      M_STEP:  n.mode = halt ? M_HALT : M_STOP;
      default: if (!run_s) n.mode = M_STOP;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) ma <= model_reset();
    else       ma <= model_step(ma, run_a, btn_a, halt_a, 2, 3);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mb <= model_reset();
    else       mb <= model_step(mb, run_b, btn_b, halt_b, 0, 3);

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_clk_en", clk_en_a, model_en(ma, 2));
    check("a_running", running_a, ma.mode == M_RUN);
    check("a_step_count", step_count_a, ma.pulses & 32'hFFFF);
    check("b_clk_en", clk_en_b, model_en(mb, 0));
    check("b_running", running_b, mb.mode == M_RUN);
    check("b_step_count", step_count_b, mb.pulses & 32'hFFFF);
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic count_a(input int n, output int p);
    p = 0;
    repeat (n) begin
      nxt();
      if (clk_en_a) p++;
    end
  endtask

  task automatic seq_a();
    int p;
    int q;
    int t;
    // free-run, SLOW=2
    nxt();
    nxt();
    run_a = 1'b1;
    nxt();
    nxt();
    check("a_run_sync_latency", running_a, 0);
    nxt();
    check("a_running_entry", running_a, 1);
    check("a_no_early_pulse", clk_en_a, 0);
    repeat (3) nxt();
    check("a_first_pulse", clk_en_a, 1);
    repeat (4) nxt();
    check("a_second_pulse", clk_en_a, 1);
    repeat (5) nxt();
    check("a_count_after_three", step_count_a, 3);
    // HALT coincident with a pulse
    repeat (3) nxt();
    check("a_pulse_at_halt", clk_en_a, 1);
    halt_a = 1'b1;
    nxt();
    halt_a = 1'b0;
    check("a_halt_pulse_counted", step_count_a, 4);
    check("a_halted_not_running", running_a, 0);
    repeat (5) nxt();
    btn_a = 1'b1;
    count_a(20, p);
    btn_a = 1'b0;
    count_a(25, q);
    check("a_halted_press_ignored", p + q, 0);
    check("a_halted_count_held", step_count_a, 4);
    run_a = 1'b0;
    repeat (4) nxt();
    check("a_stopped_count", step_count_a, 4);
    // short glitches while stopped
    t = 0;
    repeat (3) begin
      btn_a = 1'b1;
      count_a(3, q);
      t += q;
      btn_a = 1'b0;
      count_a(5, q);
      t += q;
    end
    check("a_glitch_no_pulse", t, 0);
    // clean press
    btn_a = 1'b1;
    count_a(20, p);
    btn_a = 1'b0;
    count_a(20, q);
    check("a_clean_press_one_pulse", p + q, 1);
    check("a_clean_press_count", step_count_a, 5);
    // press with bouncy release
    btn_a = 1'b1;
    count_a(20, p);
    t = 0;
    btn_a = 1'b0; count_a(2, q);  t += q;
    btn_a = 1'b1; count_a(1, q);  t += q;
    btn_a = 1'b0; count_a(3, q);  t += q;
    btn_a = 1'b1; count_a(2, q);  t += q;
    btn_a = 1'b0; count_a(20, q); t += q;
    check("a_bounce_press_pulse", p, 1);
    check("a_bounce_release_none", t, 0);
    check("a_bounce_count", step_count_a, 6);
    // randomized phase, checked cycle by cycle against the model
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      int bmode;
      int hflag;
      len   = $urandom_range(1, 60);
      bmode = $urandom_range(0, 2);
      hflag = $urandom_range(0, 1);
      run_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst_a = 1'b1;
        nxt();
        rst_a = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        btn_a  = (bmode == 2) ? 1'($urandom_range(0, 1)) : 1'(bmode);
        halt_a = (hflag != 0) && ($urandom_range(0, 15) == 0);
        nxt();
      end
    end
    halt_a = 1'b0;
  endtask

  task automatic seq_b();
    bit seen;
    run_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      nxt();
      seen = running_b;
    end
    check("b_enter_running", seen, 1);
    check("b_en_every_cycle", clk_en_b, 1);
    repeat (3) nxt();
    check("b_count_before_reset", step_count_b, 3);
    rst_b = 1'b1;
    #1;
    check("b_async_reset_clk_en", clk_en_b, 0);
    check("b_async_reset_count", step_count_b, 0);
    nxt();
    nxt();
    rst_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      nxt();
      seen = running_b;
    end
    check("b_reenter_running", seen, 1);
    check("b_count_after_reset", step_count_b, 0);
    repeat (65535) nxt();
    check("b_count_full", step_count_b, 16'hFFFF);
    check("b_en_before_wrap", clk_en_b, 1);
    nxt();
    check("b_count_wrapped", step_count_b, 0);
    nxt();
    check("b_count_after_wrap", step_count_b, 1);
  endtask

  initial begin
    rst_a = 1'b1; run_a = 1'b1; btn_a = 1'b1; halt_a = 1'b0;
    rst_b = 1'b1; run_b = 1'b1; btn_b = 1'b1; halt_b = 1'b0;
    repeat (5) begin
      nxt();
      check("rst_clk_en", clk_en_a, 0);
      check("rst_running", running_a, 0);
      check("rst_step_count", step_count_a, 0);
    end
    rst_a = 1'b0; run_a = 1'b0; btn_a = 1'b0;
    rst_b = 1'b0; run_b = 1'b0; btn_b = 1'b0;
    nxt();
    check("release_clk_en", clk_en_a, 0);
    check("release_running", running_a, 0);
    check("release_step_count", step_count_a, 0);
    fork
      seq_a();
      seq_b();
    join
    nxt();
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
